// File: rtl/bin2bcd_serializer.sv
// bin2bcd_serializer: double-dabble binary-to-BCD converter streaming digits MSD first
module bin2bcd_serializer #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  dig_valid,
  input  logic                  dig_ready,
  output logic [3:0]            dig_out,
  output logic                  dig_last,
  output logic [4*DIGITS-1:0]   bcd_word,
  output logic                  busy
);
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic [1:0] {IDLE, CONV, SEND} state_t;
  state_t              state, state_n;
  logic [BW+BIN_W-1:0] sr, sr_n;
  logic [BW-1:0]       adj, bcd;
  logic [CW-1:0]       cnt, cnt_n;
  logic [IW-1:0]       idx, idx_n;
  assign bcd       = sr[BW+BIN_W-1:BIN_W];
  assign in_ready  = state == IDLE;
  assign busy      = state != IDLE;
  assign dig_valid = state == SEND;
  assign dig_last  = dig_valid && idx == '0;
  assign bcd_word  = dig_valid ? bcd : '0;
  assign dig_out   = dig_valid ? 4'(bcd >> {idx, 2'b00}) : 4'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      sr    <= '0;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      sr    <= sr_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  // add-3 correction per digit precedes the shift of each iteration
  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    state_n = state;
    sr_n    = sr;
    cnt_n   = cnt;
    idx_n   = idx;
    case (state)
      IDLE: if (in_valid) begin
        state_n = CONV;
        sr_n    = {{BW{1'b0}}, bin_in};
        cnt_n   = CW'(BIN_W);
      end
      CONV: begin
        sr_n  = {adj, sr[BIN_W-1:0]} << 1;
        cnt_n = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          state_n = SEND;
          idx_n   = IW'(DIGITS - 1);
        end
      end
      SEND: if (dig_ready) begin
        idx_n = idx == '0 ? '0 : idx - 1'b1;
        if (idx == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_bin2bcd_serializer.sv
// tb_bin2bcd_serializer: scoreboard bench with decimal reference model and random backpressure
module tb_bin2bcd_serializer;
  localparam int BIN_W = 8, DIGITS = 3;
  typedef struct { int d; bit l; int w; } exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, dig_ready = 0;
  logic [BIN_W-1:0] bin_in = '0;
  logic in_ready, dig_valid, dig_last, busy;
  logic [3:0] dig_out;
  logic [4*DIGITS-1:0] bcd_word;
  exp_t q[$];
  int vec = 0, miss = 0;
  bit rnd_bp = 0;
  bin2bcd_serializer #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .bin_in(bin_in),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_out(dig_out), .dig_last(dig_last),
    .bcd_word(bcd_word), .busy(busy));
  always #5 clk = ~clk;
  task automatic chk(string name, int got, int exp);
    vec++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic push_exp(int v);
    int w = 0;
    for (int i = 0; i < DIGITS; i++) w += ((v / (10 ** i)) % 10) << (4 * i);
    for (int i = DIGITS - 1; i >= 0; i--) q.push_back('{(v / (10 ** i)) % 10, i == 0, w});
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
  endtask
  task automatic send(int v);
    wait_ready();
    in_valid = 1;
    bin_in   = BIN_W'(v);
    push_exp(v);
    step();
    in_valid = 0;
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 500) begin step(); n++; end
    chk("drain_timeout", q.size(), 0);
    wait_ready();
  endtask
  task automatic chk_reset_vals();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_dig_valid", dig_valid, 0);
    chk("rst_dig_last", dig_last, 0);
    chk("rst_dig_out", dig_out, 0);
    chk("rst_bcd_word", bcd_word, 0);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (dig_valid) begin
      if (q.size() == 0) chk("unexpected_digit", dig_out, -1);
      else begin
        chk("dig_out", dig_out, q[0].d);
        chk("dig_last", dig_last, q[0].l);
        chk("bcd_word", bcd_word, q[0].w);
        if (dig_ready) void'(q.pop_front());
      end
    end else begin
      chk("idle_dig_out", dig_out, 0);
      chk("idle_dig_last", dig_last, 0);
      chk("idle_bcd_word", bcd_word, 0);
    end
    chk("busy_vs_ready", busy, !in_ready);
  end
  always @(posedge clk) begin
    #1;
    if (rnd_bp) dig_ready = $urandom_range(0, 1);
  end
  initial begin
    int n;
    #2;
    chk_reset_vals();
    step();
    rst_n = 1;
    step();
    dig_ready = 1;
    send(0);
    n = 0;
    while (!dig_valid && n < 50) begin step(); n++; end
    chk("latency", n, BIN_W);
    drain();
    send(255);
    send(99);
    drain();
    dig_ready = 0;
    send(150);
    n = 0;
    while (!dig_valid && n < 50) begin step(); n++; end
    repeat (5) step();
    dig_ready = 1;
    drain();
    send(42);
    in_valid = 1;
    bin_in = 8'd77;
    step();
    chk("no_accept_in_conv", in_ready, 0);
    wait_ready();
    push_exp(77);
    step();
    in_valid = 0;
    drain();
    send(200);
    repeat (3) step();
    q.delete();
    rst_n = 0;
    #1;
    chk_reset_vals();
    step();
    step();
    rst_n = 1;
    step();
    send(13);
    drain();
    wait_ready();
    in_valid = 1;
    bin_in = 8'd128;
    push_exp(128);
    step();
    bin_in = 8'd7;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    chk("b2b_gap", n, BIN_W + DIGITS);
    push_exp(7);
    step();
    in_valid = 0;
    drain();
    rnd_bp = 1;
    for (int i = 0; i < 40; i++) send($urandom_range(0, 255));
    drain();
    rnd_bp = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end
endmodule

// File: doc/bin2bcd_serializer.md
# bin2bcd_serializer

Sequential binary-to-BCD converter that sits directly upstream of the combinational BCD-to-Excess-3 stage. It accepts one unsigned binary word per transaction and converts it with the iterative shift-and-add-3 (double-dabble) algorithm, one bit per clock. It then streams the resulting BCD digits most-significant first, one 4-bit digit per handshake, so each digit can drive the downstream 4-bit `bcd` input directly. The full BCD word is also held on a parallel output for the duration of the stream.

## Interface
- `BIN_W`, default 8: width of the binary input; legal range 4..16.
- `DIGITS`, default 3: number of BCD digits produced; must satisfy 10^DIGITS > 2^BIN_W − 1 (fixed at elaboration, not checked in RTL).

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  `bin_in` is presented.
- `in_ready`  out  1  block can accept a word (high only in IDLE).
- `bin_in`  in  BIN_W  unsigned binary value.
- `dig_valid`  out  1  `dig_out` holds a valid BCD digit.
- `dig_ready`  in  1  downstream accepts the current digit.
- `dig_out`  out  4  current BCD digit, 0..9.
- `dig_last`  out  1  current digit is the least-significant digit.
- `bcd_word`  out  4*DIGITS  full converted value, digit 0 in bits [3:0]; valid while `dig_valid` is high.
- `busy`  out  1  high in CONV and SEND.

## Operation
- FSM states: IDLE, CONV, SEND.
- IDLE: `in_ready`=1. On `in_valid && in_ready` the block loads shift register {bcd = 0, bin = `bin_in`} and the iteration counter = BIN_W, then moves to CONV.
- CONV: each cycle, every 4-bit digit of bcd that is ≥ 5 gets +3 (4-bit add, no carry out of the digit). The whole {bcd, bin} register then shifts left by 1. The counter decrements. After the BIN_W-th iteration the state moves to SEND and the digit index = DIGITS−1.
- SEND: `dig_valid`=1, `dig_out` = bcd digit[index], `dig_last` = (index == 0). On `dig_valid && dig_ready` the index decrements. The handshake on the last digit returns the FSM to IDLE.
- Leading zeros are not suppressed: exactly DIGITS digits are emitted per word.
- `in_valid` is ignored outside IDLE. `bin_in` is sampled only on the accepting edge.
- `dig_ready` is ignored outside SEND.
- Internal digits never exceed 9 after a shift, by construction of the algorithm. `dig_out` is always 0..9.

## Timing
- Reset (async, `rst_n`=0): state = IDLE, `in_ready`=1, `busy`=0, `dig_valid`=0, `dig_last`=0, `dig_out`=0, `bcd_word`=0, counter and index = 0.
- Reset asserted mid-CONV or mid-SEND aborts the transaction. No further digits are emitted. `in_ready` returns to 1 while `rst_n` is low.
- Latency: acceptance edge E0. Conversion edges are E1..E_BIN_W. `dig_valid` rises after E_BIN_W, i.e. BIN_W cycles after acceptance (8 for the defaults).
- Throughput with `dig_ready` tied high: one word per BIN_W + DIGITS + 1 cycles (12 for the defaults).
- Backpressure: while `dig_valid && !dig_ready`, the outputs `dig_out`, `dig_last` and `bcd_word` hold stable.
- After the last digit handshake at edge Ek, the state is IDLE and `in_ready`=1 in the following cycle. A new word can be accepted at E(k+1).
- `in_ready`, `busy` and `dig_valid` are decoded from registered state only; there is no combinational path from inputs to outputs.
- `dig_out`, `dig_last` and `bcd_word` are 0 whenever `dig_valid` is 0.

## Test plan
- After reset, `bin_in`=8'd0 accepted, `dig_ready`=1 → `dig_valid` rises 8 cycles later. Digits 0,0,0 are emitted on consecutive cycles; `dig_last` is high on the third; `bcd_word`=12'h000.
- `bin_in`=8'd255 → digits 2,5,5, `bcd_word`=12'h255. `bin_in`=8'd99 → digits 0,9,9.
- `bin_in`=8'd150, `dig_ready` held low 5 cycles after `dig_valid` rises → `dig_out`=1 stable for all 5 cycles and `bcd_word`=12'h150 stable. The stream 1,5,0 then completes when `dig_ready`=1.
- `in_valid`=1 with `bin_in`=8'd77 held during CONV of 8'd42 → 77 is not accepted before the stream finishes. The output is 0,4,2, then `in_ready`=1 and 77 is accepted, producing 0,7,7.
- `rst_n` pulsed low at the 4th CONV cycle of 8'd200 → outputs return to reset values immediately. No digit is emitted, and the next word 8'd13 yields 0,1,3.
- Back-to-back: 8'd128 then 8'd7 with `in_valid` held high and `dig_ready`=1 → streams 1,2,8 then 0,0,7. The second word is accepted on the cycle after `dig_last` of the first.
